// File: rtl/compress_pkg.sv
// Constants shared by the compressor write controller and the downstream state/RAM2 register.
package compress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int ADDR_W     = 20;
    localparam int NUM_BLOCKS = 16384;

    // Counter width for n blocks, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram2_index_writer_blk_counter.sv
// Block counter for one image: load-zero, increment, and a terminal flag at NUM_BLOCKS-1.
module blk_counter #(
    parameter int NUM_BLOCKS = 16384,
    parameter int CNT_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(NUM_BLOCKS - 1));

endmodule

// File: rtl/ram2_index_writer.sv
// RAM2 write-side controller: accepts one codebook index per block and writes it to
// consecutive RAM2 addresses, one write per two cycles, with a done pulse per image.
module ram2_index_writer #(
    parameter int          ADDR_W     = compress_pkg::ADDR_W,
    parameter int          IDX_W      = 8,
    parameter int          NUM_BLOCKS = compress_pkg::NUM_BLOCKS,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              idx_valid,
    input  logic [IDX_W-1:0]  idx_data,
    output logic              idx_ready,
    output logic [1:0]        state,
    output logic              ram2_we,
    output logic [ADDR_W-1:0] ram2_a,
    output logic [IDX_W-1:0]  ram2_d,
    output logic              done
);
    import compress_pkg::*;

    localparam int CNT_W = cnt_width(NUM_BLOCKS);

    state_t              state_q;
    state_t              state_n;
    logic                ready_n;
    logic                we_n;
    logic                done_n;
    logic [ADDR_W-1:0]   a_n;
    logic [IDX_W-1:0]    d_n;
    logic                cnt_clear;
    logic                cnt_inc;
    logic                cnt_last;
    logic [CNT_W-1:0]    count;
    logic                accept;

    assign accept = idx_valid && idx_ready;
    assign state  = state_q;

    blk_counter #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .CNT_W      (CNT_W)
    ) u_blk_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (count),
        .last  (cnt_last)
    );

    // State and every output are registered; reset discards any image in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_ready <= 1'b0;
            ram2_we   <= 1'b0;
            ram2_a    <= '0;
            ram2_d    <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_ready <= ready_n;
            ram2_we   <= we_n;
            ram2_a    <= a_n;
            ram2_d    <= d_n;
            done      <= done_n;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_n = ST_RUN;
            ST_RUN:   if (accept) state_n = ST_WRITE;
            ST_WRITE: state_n = cnt_last ? ST_DONE : ST_RUN;
            ST_DONE:  state_n = ST_IDLE;
        endcase
    end

    // Next values of the output registers; address and data hold between write pulses.
    always_comb begin
        ready_n   = idx_ready;
        we_n      = 1'b0;
        done_n    = 1'b0;
        a_n       = ram2_a;
        d_n       = ram2_d;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_n = start;
                cnt_clear = start;
            end
            ST_RUN: begin
                if (accept) begin
                    we_n    = 1'b1;
                    a_n     = ADDR_W'(BASE_ADDR) + ADDR_W'(count);
                    d_n     = idx_data;
                    ready_n = 1'b0;
                end
            end
            ST_WRITE: begin
                if (cnt_last) begin
                    done_n = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    ready_n = 1'b1;
                end
            end
            ST_DONE: begin
                ready_n = 1'b0;
            end
        endcase
    end

endmodule
